// File: rtl/apb_cfg_regfile.sv
// APB3 configuration register file: RW, RO status and W1P strobe registers
// with programmable wait states and error signalling.
module apb_cfg_regfile #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 16,
  parameter int NUM_REGS = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] PULSE_MASK = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [ADDR_W-1:0] paddr,
  input  logic psel,
  input  logic penable,
  input  logic pwrite,
  input  logic [DATA_W-1:0] pwdata,
  output logic pready,
  output logic [DATA_W-1:0] prdata,
  output logic pslverr,
  input  logic [NUM_REGS*DATA_W-1:0] status_in,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  output logic [NUM_REGS*DATA_W-1:0] pulse_out,
  output logic [NUM_REGS-1:0] reg_wr_stb
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int NSLOT = 1 << IDX_W;
  localparam logic [IDX_W:0] NR = (IDX_W+1)'(NUM_REGS);
  localparam logic [2:0] WC = 3'(WAIT_CYCLES);

  logic [2:0] r_wcnt;
  logic w_access;
  logic [IDX_W-1:0] w_idx;
  logic w_hit;
  logic w_wr;
  logic [NSLOT-1:0] w_ro;
  logic [DATA_W-1:0] w_rd [NSLOT];
  logic [NUM_REGS*DATA_W-1:0] w_unused_status;

  assign w_unused_status = status_in;

  assign w_access = psel & penable;
  assign pready = w_access & (r_wcnt == WC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt <= '0;
    end else if (!w_access || pready) begin
      r_wcnt <= '0;
    end else begin
      r_wcnt <= r_wcnt + 3'd1;
    end
  end

  assign w_idx = paddr[IDX_W-1:0];
  assign w_hit = (paddr[ADDR_W-1:IDX_W] == BASE_ADDR[ADDR_W-1:IDX_W])
               && ({1'b0, w_idx} < NR);

  assign pslverr = pready & (!w_hit | (pwrite & w_ro[w_idx]));
  assign w_wr = pready & !pslverr & pwrite;

  assign prdata = (pready & !pwrite & !pslverr) ? w_rd[w_idx] : '0;

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    if (g >= NUM_REGS) begin : g_none
      assign w_ro[g] = 1'b0;
      assign w_rd[g] = '0;
    end else if (RO_MASK[g]) begin : g_ro
      // Status registers own no flops; pulse bits here are ignored.
      assign w_ro[g] = 1'b1;
      assign w_rd[g] = status_in[g*DATA_W +: DATA_W];
      assign reg_out[g*DATA_W +: DATA_W] = '0;
      assign pulse_out[g*DATA_W +: DATA_W] = '0;
      assign reg_wr_stb[g] = 1'b0;
    end else begin : g_rw
      localparam logic [DATA_W-1:0] PM = PULSE_MASK[g*DATA_W +: DATA_W];
      localparam logic [DATA_W-1:0] RV = RST_VAL[g*DATA_W +: DATA_W];
      logic w_sel;
      logic [DATA_W-1:0] r_q;
      logic [DATA_W-1:0] r_p;
      logic r_stb;

      assign w_sel = w_wr && (w_idx == IDX_W'(g));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= RV & ~PM;
          r_p <= '0;
          r_stb <= 1'b0;
        end else begin
          if (w_sel) begin
            r_q <= pwdata & ~PM;
          end
          r_p <= w_sel ? (pwdata & PM) : '0;
          r_stb <= w_sel;
        end
      end

      assign w_ro[g] = 1'b0;
      assign w_rd[g] = r_q;
      assign reg_out[g*DATA_W +: DATA_W] = r_q;
      assign pulse_out[g*DATA_W +: DATA_W] = r_p;
      assign reg_wr_stb[g] = r_stb;
    end
  end

endmodule

// File: doc/apb_cfg_regfile.md
# apb_cfg_regfile

Parametrised APB3 configuration register file for the control subsystem, replacing the tied-off register stub. It decodes a word-addressed window of `NUM_REGS` 16-bit registers on the control APB bus, with three per-register access types:
- RW: read/write configuration.
- RO: sampled status.
- W1P: write-1-to-pulse strobes, for start, again and MDIO read-type controls.

It also inserts programmable wait states and flags illegal accesses through `pslverr`. Downstream packet-control, capture and MDIO-memory logic consume the flattened register outputs and pulses.

## Interface
Parameters:
- `ADDR_W`, 21: APB address width.
- `DATA_W`, 16: register and bus data width.
- `NUM_REGS`, 16: number of registers, 1..64. `IDX_W = max(1, clog2(NUM_REGS))`.
- `BASE_ADDR`, 0: window base. Bits `[ADDR_W-1:IDX_W]` of `paddr` must equal the same bits of `BASE_ADDR`.
- `WAIT_CYCLES`, 0: wait states per access, 0..7.
- `RO_MASK`, 0: `NUM_REGS` bits. A set bit makes that register read-only status.
- `PULSE_MASK`, 0: `NUM_REGS*DATA_W` bits. A set bit makes that field bit W1P.
- `RST_VAL`, 0: `NUM_REGS*DATA_W` bits, reset values of the RW bits.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `paddr`  in  ADDR_W  APB address, word-indexed
- `psel`, `penable`, `pwrite`  in  1  APB control
- `pwdata`  in  DATA_W  write data
- `pready`  out  1  access complete
- `prdata`  out  DATA_W  read data; 0 except in a read pready cycle
- `pslverr`  out  1  error; valid only with pready
- `status_in`  in  NUM_REGS*DATA_W  status words for RO registers; synchronous to `clk`
- `reg_out`  out  NUM_REGS*DATA_W  RW register contents; W1P bits read 0 here
- `pulse_out`  out  NUM_REGS*DATA_W  one-cycle W1P strobes
- `reg_wr_stb`  out  NUM_REGS  one-cycle strobe per successfully written register

## Operation
- Access phase: `psel & penable`. A 3-bit counter `wcnt` is held at 0 outside the access phase.
- While in the access phase with `wcnt != WAIT_CYCLES`, `wcnt` increments each cycle.
- `pready = psel & penable & (wcnt == WAIT_CYCLES)`. This is combinational from `wcnt`.
- Completion cycle: the cycle with `pready = 1`. `wcnt` returns to 0 on the following edge.
- Decode: `hit` when the upper address bits match `BASE_ADDR` and `idx = paddr[IDX_W-1:0]` is less than `NUM_REGS`.
- `pslverr = pready & (!hit | (pwrite & RO_MASK[idx]))`.
- An errored access has no side effects and reads `prdata = 0`.
- Write to an RW register, on the completion edge:
  - Non-pulse bits load from `pwdata`. Pulse bits stay 0.
  - For each `pwdata` bit set at a pulse position, the matching `pulse_out` bit is registered high for exactly 1 cycle.
  - `reg_wr_stb[idx]` goes high for 1 cycle, aligned with `pulse_out`.
- Read, in the completion cycle:
  - RW register: `prdata` is the register value, with pulse bits reading 0.
  - RO register: `prdata` is the `status_in` word for that register, sampled combinationally.
- Abort: if `psel` drops before completion, `wcnt` clears and there is no write, pulse or error.
- Back-to-back transfers (setup immediately after completion) are supported with no idle cycle required.
- `PULSE_MASK` bits inside an RO register are ignored.

## Timing
- Reset (async assert, sync deassert assumed upstream) drives:
  - `reg_out` to `RST_VAL`, with pulse positions forced to 0;
  - `pulse_out`, `reg_wr_stb` and `wcnt` to 0;
  - `pready`, `pslverr` and `prdata` to 0 while `psel` is low.
- Latency:
  - With `WAIT_CYCLES = N`, `pready` asserts in access cycle N+1, i.e. N wait states.
  - A full transfer takes N+2 cycles including setup.
- Write latency: `reg_out` updates on the completion edge. `pulse_out` and `reg_wr_stb` are high in the following cycle only.
- Consecutive W1P writes to the same bit produce separate 1-cycle pulses, one per completed write; pulses are never merged or stretched.
- Reset asserted mid-access: the transfer is lost, with no write or pulse. Outputs take reset values immediately.
- `status_in` changing during a wait state: the value present in the completion cycle is returned.

## Test plan
- Reset values: with `RST_VAL` reg3 = 0x00A5 and `NUM_REGS = 16`, release reset, then read every register.
  - Expect `reg_out[3] = 0x00A5` and all other registers 0.
  - Expect `pslverr = 0` on each read and `pulse_out = 0` throughout.
- RW write with wait states: `WAIT_CYCLES = 2`; write 0x1234 to idx 5.
  - Expect `pready` high only in the 3rd access cycle.
  - Expect `reg_out[5] = 0x1234` on the next cycle and `reg_wr_stb[5]` high for 1 cycle.
  - Readback returns 0x1234.
- W1P: with `PULSE_MASK` = reg2 bit0, write 0x0001 twice back-to-back.
  - Expect two separate 1-cycle `pulse_out` bit0 pulses.
  - Readback of reg2 returns 0x0000.
- RO and errors:
  - Read of RO idx 7 with `status_in = 0xBEEF` returns 0xBEEF.
  - Write to idx 7 gives `pslverr = 1` and leaves the register unchanged.
  - Read of idx 20 or of a mismatched base gives `pslverr = 1` and `prdata = 0`.
- Abort and reset:
  - Drop `psel` in a wait state: no `reg_wr_stb`, and `wcnt` returns to 0.
  - Assert `rst_n` low mid-write: the register keeps `RST_VAL` after release.
